pll_rst_sequencer: RTL and testbench

- Controls bring-up and recovery of the clock-generation PLL and the per-domain resets derived from it.
- Holds the PLL in reset, waits for a qualified lock, then releases the generated-clock domain resets one at a time in a fixed order.
- On lock loss, re-resets all domains and the PLL; a bounded retry count ends in a sticky fault.
- Runs on the PLL input (reference) clock, so it keeps running while the PLL is held in reset.

---
 rtl/pll_rst_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pll_rst_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_sequencer.sv
`timescale 1ns/1ps
// PLL bring-up sequencer: resets the PLL, qualifies lock and releases domain resets in order.
// Define PLL_SEQ_RETRY_EN to retry failed attempts up to MAX_RETRY times before the sticky fault.
module pll_rst_sequencer #(
  parameter int NUM_DOM      = 4,
  parameter int AR_CYCLES    = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STAGE_GAP    = 256,
  parameter int MAX_RETRY    = 7,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_locked,
  output logic               pll_areset,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [2:0]         state,
  output logic [RW-1:0]      retry_cnt
);

  localparam int MAX_AB = (AR_CYCLES > LOCK_STABLE) ? AR_CYCLES : LOCK_STABLE;
  localparam int MAX_CD = (LOCK_TIMEOUT > STAGE_GAP) ? LOCK_TIMEOUT : STAGE_GAP;
  localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [TW-1:0]      AR_LAST  = TW'(AR_CYCLES - 1);
  localparam logic [TW-1:0]      ST_LAST  = TW'(LOCK_STABLE - 1);
  localparam logic [TW-1:0]      TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]      GAP_LAST = TW'(STAGE_GAP - 1);
  localparam logic [NUM_DOM-1:0] DOM_ONE  = NUM_DOM'(1);

  typedef enum logic [2:0] {
    ASSERT_AR = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } state_e;

  state_e             state_q;
  logic               lock_p0;
  logic               lock_s;
  logic [TW-1:0]      ar_cnt;
  logic [TW-1:0]      to_cnt;
  logic [TW-1:0]      st_cnt;
  logic [TW-1:0]      gap_cnt;
  logic [NUM_DOM-1:0] dom_nxt;
  logic               to_done;
  logic               fail;
  logic               stable_done;
  logic               run_entry;
  logic               retry_exh;

  assign state       = state_q;
  assign to_done     = (to_cnt == TO_LAST);
  assign dom_nxt     = (dom_rst_n << 1) | DOM_ONE;
  assign stable_done = (state_q == STABLE) && lock_s && (st_cnt == ST_LAST);
  assign run_entry   = !fail &&
                       (((state_q == RELEASE) && (gap_cnt == GAP_LAST) && (&dom_nxt)) ||
                        (stable_done && (NUM_DOM == 1)));

  // Timeout expiry keeps running through STABLE, so a flapping lock cannot stall forever.
  always_comb begin
    fail = 1'b0;
    case (state_q)
      WAIT_LOCK: fail = !lock_s && to_done;
      STABLE:    fail = to_done;
      RELEASE:   fail = !lock_s;
      RUN:       fail = !lock_s;
      default:   fail = 1'b0;
    endcase
  end

`ifdef PLL_SEQ_RETRY_EN
  logic [RW-1:0] retry_q;

  assign retry_exh = (retry_q == RW'(MAX_RETRY));
  assign retry_cnt = retry_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retry_q <= '0;
    end else if (fail && !retry_exh) begin
      retry_q <= retry_q + RW'(1);
    end else if (run_entry) begin
      retry_q <= '0;
    end
  end
`else
  assign retry_exh = 1'b1;
  assign retry_cnt = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_p0    <= 1'b0;
      lock_s     <= 1'b0;
      state_q    <= ASSERT_AR;
      pll_areset <= 1'b1;
      dom_rst_n  <= '0;
      ready      <= 1'b0;
      fault      <= 1'b0;
      ar_cnt     <= '0;
      to_cnt     <= '0;
      st_cnt     <= '0;
      gap_cnt    <= '0;
    end else begin
      lock_p0 <= pll_locked;
      lock_s  <= lock_p0;
      if (fail) begin
        pll_areset <= 1'b1;
        dom_rst_n  <= '0;
        ready      <= 1'b0;
        ar_cnt     <= '0;
        if (retry_exh) begin
          state_q <= FAULT;
          fault   <= 1'b1;
        end else begin
          state_q <= ASSERT_AR;
        end
      end else begin
        case (state_q)
          ASSERT_AR: begin
            pll_areset <= 1'b1;
            if (ar_cnt == AR_LAST) begin
              state_q    <= WAIT_LOCK;
              pll_areset <= 1'b0;
              to_cnt     <= '0;
            end else begin
              ar_cnt <= ar_cnt + TW'(1);
            end
          end
          WAIT_LOCK: begin
            if (!to_done) to_cnt <= to_cnt + TW'(1);
            if (lock_s) begin
              state_q <= STABLE;
              st_cnt  <= '0;
            end
          end
          STABLE: begin
            if (!to_done) to_cnt <= to_cnt + TW'(1);
            if (!lock_s) begin
              state_q <= WAIT_LOCK;
            end else if (stable_done) begin
              dom_rst_n <= DOM_ONE;
              gap_cnt   <= '0;
              if (NUM_DOM == 1) begin
                state_q <= RUN;
                ready   <= 1'b1;
              end else begin
                state_q <= RELEASE;
              end
            end else begin
              st_cnt <= st_cnt + TW'(1);
            end
          end
          RELEASE: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt   <= '0;
              dom_rst_n <= dom_nxt;
              if (&dom_nxt) begin
                state_q <= RUN;
                ready   <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt + TW'(1);
            end
          end
          RUN: begin
            ready <= 1'b1;
          end
          FAULT: begin
            pll_areset <= 1'b1;
            dom_rst_n  <= '0;
            ready      <= 1'b0;
            fault      <= 1'b1;
          end
          default: begin
            state_q    <= ASSERT_AR;
            pll_areset <= 1'b1;
            dom_rst_n  <= '0;
            ready      <= 1'b0;
            ar_cnt     <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_rst_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for pll_rst_sequencer: expected output snapshots are queued per clock cycle.
module tb_pll_rst_sequencer;

  localparam int NUM_DOM      = 4;
  localparam int AR_CYCLES    = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 64;
  localparam int STAGE_GAP    = 4;
  localparam int MAX_RETRY    = 2;
  localparam int RW           = $clog2(MAX_RETRY + 1);
  localparam int OW           = 3 + 1 + NUM_DOM + 1 + 1 + RW;
  localparam int ALL_DOM      = (1 << NUM_DOM) - 1;
`ifdef PLL_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               pll_locked = 1'b0;
  logic               pll_areset;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic               ready;
  logic               fault;
  logic [2:0]         state;
  logic [RW-1:0]      retry_cnt;
  logic [OW-1:0]      obs;

  always #5 clk = ~clk;

  pll_rst_sequencer #(
    .NUM_DOM(NUM_DOM), .AR_CYCLES(AR_CYCLES), .LOCK_STABLE(LOCK_STABLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .STAGE_GAP(STAGE_GAP), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .pll_areset(pll_areset),
    .dom_rst_n(dom_rst_n), .ready(ready), .fault(fault), .state(state),
    .retry_cnt(retry_cnt)
  );

  assign obs = {state, pll_areset, dom_rst_n, ready, fault, retry_cnt};

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [OW-1:0] exp;
    string         tag;
  } sb_t;

  sb_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] vec(input int st, input bit ar, input int dom,
                                        input bit rdy, input bit flt, input int rc);
    logic [2:0]         s3;
    logic [NUM_DOM-1:0] d;
    logic [RW-1:0]      r;
    s3 = st[2:0];
    d  = dom[NUM_DOM-1:0];
    r  = rc[RW-1:0];
    return {s3, ar, d, rdy, flt, r};
  endfunction

  task automatic expect_at(input int c, input string tag, input logic [OW-1:0] e);
    sb_t item;
    int  i;
    item.cyc = c;
    item.exp = e;
    item.tag = tag;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, item);
  endtask

  // Pop every snapshot due this cycle, sampled half a period after the active edge.
  always @(negedge clk) begin
    sb_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) check_eq({e.tag, "_missed"}, 32'(e.cyc), 32'(cyc));
      else             check_eq(e.tag, 32'(obs), 32'(e.exp));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_rst(output int r);
    rst = 1'b1;
    r   = cyc;
    expect_at(r, "rst_state", vec(0, 1'b1, 0, 1'b0, 1'b0, 0));
    expect_at(r + AR_CYCLES - 1, "ar_hold", vec(0, 1'b1, 0, 1'b0, 1'b0, 0));
    expect_at(r + AR_CYCLES, "ar_done", vec(1, 1'b0, 0, 1'b0, 1'b0, 0));
  endtask

  task automatic do_reset(output int r);
    rst = 1'b0;
    tick(2);
    release_rst(r);
  endtask

  // l is the cycle at which a steady lock is first presented to the synchroniser.
  task automatic exp_bringup(input int l, input int rc, input string tag);
    int base;
    int d;
    bit last;
    expect_at(l + 2, {tag, "_wait"}, vec(1, 1'b0, 0, 1'b0, 1'b0, rc));
    expect_at(l + 3, {tag, "_stable"}, vec(2, 1'b0, 0, 1'b0, 1'b0, rc));
    expect_at(l + 2 + LOCK_STABLE, {tag, "_stable_end"}, vec(2, 1'b0, 0, 1'b0, 1'b0, rc));
    base = l + 3 + LOCK_STABLE;
    for (int k = 0; k < NUM_DOM; k++) begin
      d    = (1 << (k + 1)) - 1;
      last = (k == NUM_DOM - 1);
      expect_at(base + k * STAGE_GAP, $sformatf("%s_rel%0d", tag, k),
                vec(last ? 4 : 3, 1'b0, d, last, 1'b0, last ? 0 : rc));
      if (k > 0)
        expect_at(base + k * STAGE_GAP - 1, $sformatf("%s_gap%0d", tag, k),
                  vec(3, 1'b0, (1 << k) - 1, 1'b0, 1'b0, rc));
    end
  endtask

  localparam int RUN_OFS = 3 + LOCK_STABLE + (NUM_DOM - 1) * STAGE_GAP;

  initial begin
    int r;
    int l;
    int p;
    int fz;
    int f;
    tick(1);

    // Clean bring-up
    pll_locked = 1'b0;
    do_reset(r);
    wait_until(r + 10);
    pll_locked = 1'b1;
    l = cyc;
    exp_bringup(l, 0, "clean");
    wait_until(l + RUN_OFS + 3);

    // Lock glitch during STABLE
    pll_locked = 1'b0;
    do_reset(r);
    wait_until(r + 10);
    pll_locked = 1'b1;
    l = cyc;
    expect_at(l + 7, "glitch_in_stable", vec(2, 1'b0, 0, 1'b0, 1'b0, 0));
    expect_at(l + 8, "glitch_back_wait", vec(1, 1'b0, 0, 1'b0, 1'b0, 0));
    expect_at(l + 9, "glitch_still_wait", vec(1, 1'b0, 0, 1'b0, 1'b0, 0));
    tick(5);
    pll_locked = 1'b0;
    tick(2);
    pll_locked = 1'b1;
    l = cyc;
    exp_bringup(l, 0, "glitch");
    wait_until(l + RUN_OFS + 3);

    // Single-cycle lock loss in RUN
    p = cyc;
    expect_at(p + 2, "loss_pre", vec(4, 1'b0, ALL_DOM, 1'b1, 1'b0, 0));
    if (RETRY_EN) begin
      expect_at(p + 3, "loss_hit", vec(0, 1'b1, 0, 1'b0, 1'b0, 1));
      expect_at(p + 3 + AR_CYCLES - 1, "loss_ar", vec(0, 1'b1, 0, 1'b0, 1'b0, 1));
      exp_bringup(p + 5, 1, "relock");
    end else begin
      expect_at(p + 3, "loss_fault", vec(5, 1'b1, 0, 1'b0, 1'b1, 0));
      expect_at(p + 20, "loss_fault_hold", vec(5, 1'b1, 0, 1'b0, 1'b1, 0));
    end
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    wait_until(p + 5 + RUN_OFS + 3);

    // Lock timeout, retries, then sticky fault
    pll_locked = 1'b0;
    do_reset(r);
    if (RETRY_EN) begin
      for (int a = 0; a <= MAX_RETRY; a++) begin
        f = r + (a + 1) * (AR_CYCLES + LOCK_TIMEOUT);
        expect_at(f - 1, $sformatf("to_wait%0d", a), vec(1, 1'b0, 0, 1'b0, 1'b0, a));
        if (a < MAX_RETRY)
          expect_at(f, $sformatf("to_retry%0d", a), vec(0, 1'b1, 0, 1'b0, 1'b0, a + 1));
        else
          expect_at(f, "to_fault", vec(5, 1'b1, 0, 1'b0, 1'b1, a));
      end
      fz = r + (MAX_RETRY + 1) * (AR_CYCLES + LOCK_TIMEOUT);
      expect_at(fz + 30, "to_fault_sticky", vec(5, 1'b1, 0, 1'b0, 1'b1, MAX_RETRY));
    end else begin
      fz = r + AR_CYCLES + LOCK_TIMEOUT;
      expect_at(fz - 1, "to_wait0", vec(1, 1'b0, 0, 1'b0, 1'b0, 0));
      expect_at(fz, "to_fault", vec(5, 1'b1, 0, 1'b0, 1'b1, 0));
      expect_at(fz + 30, "to_fault_sticky", vec(5, 1'b1, 0, 1'b0, 1'b1, 0));
    end
    wait_until(fz + 5);
    pll_locked = 1'b1;
    wait_until(fz + 32);

    // Asynchronous reset in the middle of RELEASE
    pll_locked = 1'b0;
    do_reset(r);
    wait_until(r + 10);
    pll_locked = 1'b1;
    l = cyc;
    expect_at(l + 3 + LOCK_STABLE, "mid_rel0", vec(3, 1'b0, 1, 1'b0, 1'b0, 0));
    expect_at(l + 4 + LOCK_STABLE + STAGE_GAP - 1, "mid_rel1", vec(3, 1'b0, 3, 1'b0, 1'b0, 0));
    wait_until(l + 4 + LOCK_STABLE + STAGE_GAP);
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_rst", 32'(obs), 32'(vec(0, 1'b1, 0, 1'b0, 1'b0, 0)));
    tick(2);
    check_eq("async_rst_hold", 32'(obs), 32'(vec(0, 1'b1, 0, 1'b0, 1'b0, 0)));
    release_rst(r);
    exp_bringup(r + 2, 0, "reseq");
    wait_until(r + 2 + RUN_OFS + 3);

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300us;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
